// File: rtl/rename_map_if.sv
// -----------------------------------------------------------------------------
// rename_map_if
//
// Groups the signals between decode/retire logic and the register-rename stage.
//
//   master : drives decoded instructions, the dispatch-side ready, commits and
//            flush; observes in_ready and the renamed output.
//   slave  : the rename stage (rename_map).
//
// Signal summary:
//   in_valid / in_ready      decoded instruction handshake
//   map_en, regwrite         decode controls for lane A
//   rs1, rs2, rd             architectural register fields
//   out_valid / out_ready    renamed-instruction handshake toward dispatch
//   prs1, prs2, prd, old_prd physical tags of the renamed instruction
//   commit_*                 one retiring instruction per cycle
//   flush                    squash every speculative rename
// -----------------------------------------------------------------------------
interface rename_map_if #(
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              map_en;
  logic              regwrite;
  logic [AREG_W-1:0] rs1;
  logic [AREG_W-1:0] rs2;
  logic [AREG_W-1:0] rd;

  logic              out_valid;
  logic              out_ready;
  logic [PREG_W-1:0] prs1;
  logic [PREG_W-1:0] prs2;
  logic [PREG_W-1:0] prd;
  logic [PREG_W-1:0] old_prd;

  logic              commit_valid;
  logic [AREG_W-1:0] commit_rd;
  logic [PREG_W-1:0] commit_prd;
  logic [PREG_W-1:0] commit_old_prd;

  logic              flush;

  modport master (
    output in_valid, map_en, regwrite, rs1, rs2, rd,
    output out_ready,
    output commit_valid, commit_rd, commit_prd, commit_old_prd,
    output flush,
    input  in_ready, out_valid, prs1, prs2, prd, old_prd
  );

  modport slave (
    input  in_valid, map_en, regwrite, rs1, rs2, rd,
    input  out_ready,
    input  commit_valid, commit_rd, commit_prd, commit_old_prd,
    input  flush,
    output in_ready, out_valid, prs1, prs2, prd, old_prd
  );
endinterface

// File: rtl/rename_map.sv
// -----------------------------------------------------------------------------
// rename_map
//
// Register-rename stage for lane A. Translates architectural source registers
// into physical tags through a speculative map, allocates a fresh physical
// destination from a bit-vector free list, and keeps a committed map plus a
// committed free vector so a flush can restore the last retired state.
// One rename per cycle, result registered toward dispatch (latency 1).
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   rn     rename_map_if.slave -- decode input, dispatch output, commit, flush
//
// Physical register p0 is permanently bound to x0: it is never allocated,
// never freed and never written into either map.
// -----------------------------------------------------------------------------
module rename_map #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PREG_W    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  rename_map_if.slave rn
);

  localparam int AREG_W = $clog2(ARCH_REGS);

  // Tags ARCH_REGS..PHYS_REGS-1 start free; the lower tags hold the identity map.
  localparam logic [PHYS_REGS-1:0] FREE_INIT =
    {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PREG_W-1:0]    spec_map [ARCH_REGS];
  logic [PREG_W-1:0]    arch_map [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_vec;
  logic [PHYS_REGS-1:0] arch_free_vec;

  logic                 out_valid_q;
  logic [PREG_W-1:0]    prs1_q;
  logic [PREG_W-1:0]    prs2_q;
  logic [PREG_W-1:0]    prd_q;
  logic [PREG_W-1:0]    old_prd_q;

  // ---------------------------------------------------------------------------
  // Combinational decisions
  // ---------------------------------------------------------------------------
  logic                 need_alloc;
  logic                 fire;
  logic                 alloc_fire;
  logic                 commit_ok;
  logic                 commit_frees;
  logic [PREG_W-1:0]    alloc_tag;
  logic [PREG_W-1:0]    src1_tag;
  logic [PREG_W-1:0]    src2_tag;
  logic [PREG_W-1:0]    dst_old_tag;
  logic [PHYS_REGS-1:0] arch_free_nxt;
  logic [PHYS_REGS-1:0] free_nxt;

  assign need_alloc = rn.map_en & rn.regwrite & (rn.rd != '0);

  // A tag is only handed out while one is actually free; instructions that do
  // not allocate are never blocked by an empty free list.
  assign rn.in_ready = ~rn.flush
                     & (~out_valid_q | rn.out_ready)
                     & (~need_alloc | (|free_vec));

  assign fire       = rn.in_valid & rn.in_ready;
  assign alloc_fire = fire & need_alloc;

  // Commits naming x0 or p0 carry no mapping and are dropped entirely; an
  // old mapping of p0 has nothing to return to the free list.
  assign commit_ok    = rn.commit_valid & (rn.commit_rd != '0) & (rn.commit_prd != '0);
  assign commit_frees = commit_ok & (rn.commit_old_prd != '0);

  // Lowest-index free tag. Scanning from the top down lets the last hit, the
  // lowest index, win. Bit 0 is never free, so it is skipped.
  always_comb begin
    // NOTE: every always_comb output gets a default before any condition so
    // that no path leaves it unassigned and no latch is inferred.
    alloc_tag = '0;
    for (int i = PHYS_REGS - 1; i >= 1; i--) begin
      if (free_vec[i]) alloc_tag = PREG_W'(i);
    end
  end

  // Sources are looked up in the map as it stood before this cycle's rd update.
  assign src1_tag    = (rn.map_en && rn.rs1 != '0) ? spec_map[rn.rs1] : '0;
  assign src2_tag    = (rn.map_en && rn.rs2 != '0) ? spec_map[rn.rs2] : '0;
  assign dst_old_tag = need_alloc ? spec_map[rn.rd] : '0;

  // Committed free vector after this cycle's retirement; a flush in the same
  // cycle restores from this value so the retiring instruction is honoured.
  always_comb begin
    arch_free_nxt = arch_free_vec;
    if (commit_ok)    arch_free_nxt[rn.commit_prd]     = 1'b0;
    if (commit_frees) arch_free_nxt[rn.commit_old_prd] = 1'b1;
    arch_free_nxt[0] = 1'b0;
  end

  // Speculative free vector. The allocator above already used the pre-edge
  // value, so a tag released by a commit becomes allocatable next cycle.
  always_comb begin
    free_nxt = free_vec;
    if (alloc_fire)   free_nxt[alloc_tag]         = 1'b0;
    if (commit_frees) free_nxt[rn.commit_old_prd] = 1'b1;
    if (rn.flush)     free_nxt                    = arch_free_nxt;
    free_nxt[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Free vectors
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is written with non-blocking assignments only,
      // so every flop samples the pre-edge values of its neighbours.
      free_vec      <= FREE_INIT;
      arch_free_vec <= FREE_INIT;
    end else begin
      free_vec      <= free_nxt;
      arch_free_vec <= arch_free_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Committed map
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are reset on purpose: the identity mapping xi -> pi
      // is architectural state that must hold from the first instruction, so
      // they cannot be left to power up as RAM contents.
      for (int i = 0; i < ARCH_REGS; i++) arch_map[i] <= PREG_W'(i);
    end else if (commit_ok) begin
      arch_map[rn.commit_rd] <= rn.commit_prd;
    end
  end

  // ---------------------------------------------------------------------------
  // Speculative map
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) spec_map[i] <= PREG_W'(i);
    end else if (rn.flush) begin
      // Restore to the committed map including a commit in this same cycle.
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map[i] <= (commit_ok && rn.commit_rd == AREG_W'(i)) ? rn.commit_prd
                                                                 : arch_map[i];
      end
    end else if (alloc_fire) begin
      spec_map[rn.rd] <= alloc_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register toward dispatch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      prs1_q      <= '0;
      prs2_q      <= '0;
      prd_q       <= '0;
      old_prd_q   <= '0;
    end else if (rn.flush) begin
      out_valid_q <= 1'b0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      prs1_q      <= src1_tag;
      prs2_q      <= src2_tag;
      prd_q       <= need_alloc ? alloc_tag : '0;
      old_prd_q   <= dst_old_tag;
    end else if (rn.out_ready) begin
      // Transfer completed with nothing new behind it; payload is held as-is.
      out_valid_q <= 1'b0;
    end
  end

  assign rn.out_valid = out_valid_q;
  assign rn.prs1      = prs1_q;
  assign rn.prs2      = prs2_q;
  assign rn.prd       = prd_q;
  assign rn.old_prd   = old_prd_q;

endmodule

// File: tb/tb_rename_map.sv
// -----------------------------------------------------------------------------
// tb_rename_map
//
// Scoreboard bench for rename_map. The stimulus side drives inputs just after
// the rising edge, and a reference model evaluates each cycle just after the
// falling edge, pushing the expected renamed instruction when it predicts a
// fire. An independent monitor on the falling edge compares the DUT output
// against the head of the queue and pops it on every out_valid & out_ready.
// The model keeps whole-register tables and free flags, and picks the lowest
// free tag with a linear search.
// -----------------------------------------------------------------------------
module tb_rename_map;

  localparam int NA     = 32;
  localparam int NP     = 64;
  localparam int PREG_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rename_map_if #(.PREG_W(PREG_W), .AREG_W(5)) rn ();

  rename_map #(.ARCH_REGS(NA), .PHYS_REGS(NP), .PREG_W(PREG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rn    (rn)
  );

  typedef struct packed {
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
  } out_t;

  typedef struct {
    int rd;
    int prd;
    int old_prd;
  } rob_t;

  out_t exp_q[$];
  rob_t rob[$];

  int checks = 0;
  int errors = 0;

  // Reference state
  int smap[NA];
  int amap[NA];
  bit sfree[NP];
  bit afree[NP];
  bit m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      smap[i] = i;
      amap[i] = i;
    end
    for (int p = 0; p < NP; p++) begin
      sfree[p] = (p >= NA);
      afree[p] = (p >= NA);
    end
    m_ov = 1'b0;
    exp_q.delete();
    rob.delete();
  endtask

  // One cycle of the reference behaviour, evaluated from the sampled inputs.
  task automatic model_step();
    bit   need, rdy, fire, cok;
    int   lo;
    out_t e;
    rob_t r;
    need = rn.map_en && rn.regwrite && (rn.rd != 0);
    lo = 0;
    for (int p = 1; p < NP; p++) begin
      if (sfree[p] && lo == 0) lo = p;
    end
    rdy = !rn.flush && (!m_ov || rn.out_ready) && (!need || lo != 0);
    check("in_ready", rn.in_ready, rdy);
    fire = rn.in_valid && rdy;
    if (fire) begin
      e.prs1 = (rn.map_en && rn.rs1 != 0) ? smap[rn.rs1] : 0;
      e.prs2 = (rn.map_en && rn.rs2 != 0) ? smap[rn.rs2] : 0;
      if (need) begin
        e.prd     = lo;
        e.old_prd = smap[rn.rd];
        r.rd      = rn.rd;
        r.prd     = lo;
        r.old_prd = smap[rn.rd];
        rob.push_back(r);
        smap[rn.rd] = lo;
        sfree[lo]   = 1'b0;
      end else begin
        e.prd     = 0;
        e.old_prd = 0;
      end
      exp_q.push_back(e);
    end
    cok = rn.commit_valid && rn.commit_rd != 0 && rn.commit_prd != 0;
    if (cok) begin
      amap[rn.commit_rd]   = rn.commit_prd;
      afree[rn.commit_prd] = 1'b0;
      if (rn.commit_old_prd != 0) begin
        afree[rn.commit_old_prd] = 1'b1;
        sfree[rn.commit_old_prd] = 1'b1;
      end
    end
    if (rn.flush) begin
      smap  = amap;
      sfree = afree;
      if (!rn.out_ready) exp_q.delete();
      rob.delete();
      m_ov = 1'b0;
    end else if (fire) begin
      m_ov = 1'b1;
    end else if (rn.out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  // Monitor: output valid must match the scoreboard occupancy, a held output
  // must match the head entry every cycle, and a transfer pops it.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", rn.out_valid, exp_q.size() != 0);
      if (rn.out_valid && exp_q.size() != 0) begin
        check("prs1",    rn.prs1,    exp_q[0].prs1);
        check("prs2",    rn.prs2,    exp_q[0].prs2);
        check("prd",     rn.prd,     exp_q[0].prd);
        check("old_prd", rn.old_prd, exp_q[0].old_prd);
        if (rn.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    rn.in_valid       = 1'b0;
    rn.map_en         = 1'b0;
    rn.regwrite       = 1'b0;
    rn.rs1            = '0;
    rn.rs2            = '0;
    rn.rd             = '0;
    rn.commit_valid   = 1'b0;
    rn.commit_rd      = '0;
    rn.commit_prd     = '0;
    rn.commit_old_prd = '0;
    rn.flush          = 1'b0;
  endtask

  task automatic set_in(input bit v, input bit men, input bit rw,
                        input int r1, input int r2, input int d);
    rn.in_valid = v;
    rn.map_en   = men;
    rn.regwrite = rw;
    rn.rs1      = 5'(r1);
    rn.rs2      = 5'(r2);
    rn.rd       = 5'(d);
  endtask

  // Retire the oldest surviving allocating rename.
  task automatic set_commit();
    rob_t c;
    if (rob.size() != 0) begin
      c = rob.pop_front();
      rn.commit_valid   = 1'b1;
      rn.commit_rd      = 5'(c.rd);
      rn.commit_prd     = PREG_W'(c.prd);
      rn.commit_old_prd = PREG_W'(c.old_prd);
    end
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
    rn.in_valid     = 1'b0;
    rn.commit_valid = 1'b0;
    rn.flush        = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    rn.out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rn.out_ready = 1'b1;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", rn.out_valid, 0);
    check("rst_prs1",      rn.prs1,      0);
    check("rst_prs2",      rn.prs2,      0);
    check("rst_prd",       rn.prd,       0);
    check("rst_old_prd",   rn.old_prd,   0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", rn.in_ready, 1);

    // add x5,x1,x2 then a back-to-back x5 write reading x5
    set_in(1, 1, 1, 1, 2, 5);
    tick();
    check("t1_out_valid", rn.out_valid, 1);
    check("t1_prs1",      rn.prs1,      1);
    check("t1_prs2",      rn.prs2,      2);
    check("t1_prd",       rn.prd,       32);
    check("t1_old_prd",   rn.old_prd,   5);
    set_in(1, 1, 1, 5, 3, 5);
    tick();
    check("t2_prs1",    rn.prs1,    32);
    check("t2_prd",     rn.prd,     33);
    check("t2_old_prd", rn.old_prd, 32);
    tick();

    // Exhaust the free list; the first rename writes x7 so the oldest commit
    // releases p7.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_in(1, 1, 1, $urandom_range(0, 31), $urandom_range(0, 31),
             (i == 0) ? 7 : $urandom_range(1, 31));
      tick();
    end
    set_in(1, 0, 0, 3, 4, 9);
    #1;
    check("empty_nonalloc_ready", rn.in_ready, 1);
    tick();
    set_in(1, 1, 1, 1, 2, 8);
    #1;
    check("empty_alloc_stall", rn.in_ready, 0);
    tick();
    set_in(1, 1, 1, 1, 2, 8);
    set_commit();
    #1;
    check("commit_cycle_stall", rn.in_ready, 0);
    tick();
    set_in(1, 1, 1, 1, 2, 8);
    #1;
    check("after_commit_ready", rn.in_ready, 1);
    tick();
    check("freed_p7_prd", rn.prd, 7);
    tick();

    // Output stall for three cycles, then exactly one transfer
    do_reset();
    rn.out_ready = 1'b0;
    set_in(1, 1, 1, 4, 6, 10);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 1, 1, 0);
      #1;
      check("stall_in_ready", rn.in_ready, 0);
      tick();
    end
    rn.out_ready = 1'b1;
    tick();
    tick();

    // Commit x5 -> p32, two more speculative x5 renames, then flush. The
    // commit also returns p5, which is therefore the lowest free tag; p33
    // and p34 come back after it in order.
    do_reset();
    set_in(1, 1, 1, 0, 0, 5);
    tick();
    set_in(1, 1, 1, 0, 0, 5);
    set_commit();
    tick();
    set_in(1, 1, 1, 0, 0, 5);
    tick();
    rn.flush = 1'b1;
    tick();
    set_in(1, 1, 1, 5, 0, 6);
    tick();
    check("flush_prs1", rn.prs1, 32);
    check("flush_prd",  rn.prd,  5);
    set_in(1, 1, 1, 0, 0, 7);
    tick();
    check("flush_realloc33", rn.prd, 33);
    set_in(1, 1, 1, 0, 0, 8);
    tick();
    check("flush_realloc34", rn.prd, 34);

    // rd=x0 with regwrite, and map_en=0: no tags, free list untouched
    do_reset();
    set_in(1, 1, 1, 1, 2, 0);
    tick();
    check("x0_prd",     rn.prd,     0);
    check("x0_old_prd", rn.old_prd, 0);
    set_in(1, 0, 1, 3, 4, 9);
    tick();
    check("nomap_prs1", rn.prs1, 0);
    check("nomap_prs2", rn.prs2, 0);
    check("nomap_prd",  rn.prd,  0);
    set_in(1, 1, 1, 0, 0, 9);
    tick();
    check("untouched_prd", rn.prd, 32);

    // Reset asserted while the output is stalled
    rn.out_ready = 1'b0;
    set_in(1, 1, 1, 2, 3, 11);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", rn.out_valid, 0);
    clear_inputs();
    model_reset();
    rn.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with commits and occasional flushes
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 19) < 17,
             $urandom_range(0, 9) < 8, $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31));
      rn.out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) < 4) set_commit();
      rn.flush = $urandom_range(0, 99) < 3;
      tick();
    end
    rn.out_ready = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
